// File: rtl/procyon_core_pkg.sv
// Shared core definitions for the Procyon writeback path.
//   - PCYN_* : default widths of the core's result fields
//   - pcyn_cdb_entry_t : one CDB broadcast record {data, addr, tag, redirect}
//   - pcyn_ptr_width() : index width for a power-of-two ring buffer
package procyon_core_pkg;

  localparam int unsigned PCYN_DATA_WIDTH    = 32;
  localparam int unsigned PCYN_ADDR_WIDTH    = 32;
  localparam int unsigned PCYN_ROB_IDX_WIDTH = 5;

  typedef struct packed {
    logic [PCYN_DATA_WIDTH-1:0]    data;
    logic [PCYN_ADDR_WIDTH-1:0]    addr;
    logic [PCYN_ROB_IDX_WIDTH-1:0] tag;
    logic                          redirect;
  } pcyn_cdb_entry_t;

  function automatic int unsigned pcyn_ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/procyon_ieu_cdb_fifo.sv
// Ring-buffer FIFO holding IEU results waiting for the CDB.
//   clk, n_rst : clock, asynchronous active-low reset
//   i_flush    : discard all entries at the next edge (push/pop ignored)
//   i_push     : write i_wdata at the tail
//   i_pop      : retire the head entry (ignored when empty)
//   o_rdata    : head entry payload
//   o_count    : number of held entries (0..OPTN_DEPTH)
//   o_empty    : no entries held
//   o_full     : all OPTN_DEPTH entries held
module procyon_ieu_cdb_fifo
  import procyon_core_pkg::*;
#(
  parameter int unsigned OPTN_DEPTH = 4,
  parameter int unsigned OPTN_WIDTH = 70
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic                                   i_flush,
  input  logic                                   i_push,
  input  logic                                   i_pop,
  input  logic [OPTN_WIDTH-1:0]                  i_wdata,
  output logic [OPTN_WIDTH-1:0]                  o_rdata,
  output logic [pcyn_ptr_width(OPTN_DEPTH):0]    o_count,
  output logic                                   o_empty,
  output logic                                   o_full
);

  localparam int unsigned PTR_W = pcyn_ptr_width(OPTN_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [OPTN_WIDTH-1:0] mem_q [OPTN_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [OPTN_DEPTH-1:0] valid_q, valid_d;
  logic                  push_en, pop_en;

  assign push_en = i_push & ~i_flush;
  assign pop_en  = i_pop & ~i_flush & ~o_empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      // Clear before set: when full, push and pop address the same slot.
      if (pop_en) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      if (push_en) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[tail_q] <= i_wdata;
  end

  assign o_rdata = mem_q[head_q];
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_W'(OPTN_DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (!n_rst)
    !(push_en && o_full && !pop_en));

  a_valid_tracks_count: assert property (@(posedge clk) disable iff (!n_rst)
    valid_q[head_q] == !o_empty);

endmodule

// File: rtl/procyon_ieu_cdb_buf.sv
// IEU writeback buffer: queues registered IEU results and broadcasts them
// on the CDB in arrival order using a req/gnt handshake.
//   clk, n_rst            : clock, asynchronous active-low reset
//   i_flush               : drop buffered and incoming results
//   i_data/addr/tag/redirect, i_valid : IEU result stream
//   o_full                : stall IEU issue (one skid entry kept free)
//   o_cdb_req, i_cdb_gnt  : CDB request / grant
//   o_cdb_data/addr/tag/redirect : broadcast payload, valid while o_cdb_req
// Build option: define PCYN_IEU_CDB_BYPASS_EN to forward a result straight
// to the CDB in its arrival cycle when the buffer is empty.
module procyon_ieu_cdb_buf
  import procyon_core_pkg::*;
#(
  parameter int unsigned OPTN_DATA_WIDTH    = 32,
  parameter int unsigned OPTN_ADDR_WIDTH    = 32,
  parameter int unsigned OPTN_ROB_IDX_WIDTH = 5,
  parameter int unsigned OPTN_WB_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_data,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_addr,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_tag,
  input  logic                          i_redirect,
  input  logic                          i_valid,
  output logic                          o_full,
  output logic                          o_cdb_req,
  input  logic                          i_cdb_gnt,
  output logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_cdb_addr,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag,
  output logic                          o_cdb_redirect
);

  localparam int unsigned CNT_W = pcyn_ptr_width(OPTN_WB_DEPTH) + 1;

  // Same field order as pcyn_cdb_entry_t, sized by this instance's options.
  typedef struct packed {
    logic [OPTN_DATA_WIDTH-1:0]    data;
    logic [OPTN_ADDR_WIDTH-1:0]    addr;
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag;
    logic                          redirect;
  } cdb_entry_t;

  localparam int unsigned ENTRY_W = $bits(cdb_entry_t);

  cdb_entry_t       in_entry, head_entry, out_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;
  logic             byp_req, push, pop;

  assign in_entry = '{data: i_data, addr: i_addr, tag: i_tag, redirect: i_redirect};

`ifdef PCYN_IEU_CDB_BYPASS_EN
  assign byp_req = fifo_empty & i_valid & ~i_flush;
`else
  assign byp_req = 1'b0;
`endif

  always_comb begin
    o_cdb_req = ~fifo_empty | byp_req;
    out_entry = head_entry;
`ifdef PCYN_IEU_CDB_BYPASS_EN
    if (fifo_empty) out_entry = in_entry;
`endif
    // A bypassed result that wins the bus never occupies a slot.
    push   = i_valid & ~i_flush & ~(byp_req & i_cdb_gnt);
    pop    = ~fifo_empty & i_cdb_gnt & ~i_flush;
    o_full = (fifo_count >= CNT_W'(OPTN_WB_DEPTH - 1));
  end

  assign o_cdb_data     = out_entry.data;
  assign o_cdb_addr     = out_entry.addr;
  assign o_cdb_tag      = out_entry.tag;
  assign o_cdb_redirect = out_entry.redirect;

  procyon_ieu_cdb_fifo #(
    .OPTN_DEPTH (OPTN_WB_DEPTH),
    .OPTN_WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_flush (i_flush),
    .i_push  (push),
    .i_pop   (pop),
    .i_wdata (in_entry),
    .o_rdata (head_entry),
    .o_count (fifo_count),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  a_full_implies_stall: assert property (@(posedge clk) disable iff (!n_rst)
    fifo_full |-> o_full);

endmodule

// File: tb/tb_procyon_ieu_cdb_buf.sv
module tb_procyon_ieu_cdb_buf;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int TW    = 5;
  localparam int DEPTH = 4;
`ifdef PCYN_IEU_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          i_flush;
  logic [DW-1:0] i_data;
  logic [AW-1:0] i_addr;
  logic [TW-1:0] i_tag;
  logic          i_redirect;
  logic          i_valid;
  logic          o_full;
  logic          o_cdb_req;
  logic          i_cdb_gnt;
  logic [DW-1:0] o_cdb_data;
  logic [AW-1:0] o_cdb_addr;
  logic [TW-1:0] o_cdb_tag;
  logic          o_cdb_redirect;

  always #5 clk = ~clk;

  procyon_ieu_cdb_buf #(
    .OPTN_DATA_WIDTH    (DW),
    .OPTN_ADDR_WIDTH    (AW),
    .OPTN_ROB_IDX_WIDTH (TW),
    .OPTN_WB_DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_flush        (i_flush),
    .i_data         (i_data),
    .i_addr         (i_addr),
    .i_tag          (i_tag),
    .i_redirect     (i_redirect),
    .i_valid        (i_valid),
    .o_full         (o_full),
    .o_cdb_req      (o_cdb_req),
    .i_cdb_gnt      (i_cdb_gnt),
    .o_cdb_data     (o_cdb_data),
    .o_cdb_addr     (o_cdb_addr),
    .o_cdb_tag      (o_cdb_tag),
    .o_cdb_redirect (o_cdb_redirect)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic          redirect;
  } ent_t;

  // Reference model: the buffer is just an ordered queue of results.
  ent_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Values seen on the outputs during the most recent step.
  logic          s_req, s_full;
  logic [TW-1:0] s_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input int t, input int d);
    ent_t e;
    e.tag      = TW'(t);
    e.data     = DW'(d);
    e.addr     = AW'(32'h1000 + t * 4);
    e.redirect = t[0];
    return e;
  endfunction

  // One clock: drive at the falling edge, check against the queue model,
  // then let the rising edge happen and update the model.
  task automatic step(input bit v, input ent_t e, input bit g, input bit f);
    bit   ereq, efull, byp;
    ent_t eh;
    @(negedge clk);
    i_valid = v;
    {i_data, i_addr, i_tag, i_redirect} = e;
    i_cdb_gnt = g;
    i_flush   = f;
    #1;
    byp   = BYP && (q.size() == 0) && v && !f;
    ereq  = (q.size() != 0) || byp;
    eh    = (q.size() != 0) ? q[0] : e;
    efull = (q.size() >= DEPTH - 1);
    s_req = o_cdb_req; s_full = o_full; s_tag = o_cdb_tag;
    chk("req", 64'(o_cdb_req), 64'(ereq));
    chk("full", 64'(o_full), 64'(efull));
    if (ereq) begin
      chk("tag", 64'(o_cdb_tag), 64'(eh.tag));
      chk("data", 64'(o_cdb_data), 64'(eh.data));
      chk("addr", 64'(o_cdb_addr), 64'(eh.addr));
      chk("redirect", 64'(o_cdb_redirect), 64'(eh.redirect));
    end
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (ereq && g && q.size() != 0) void'(q.pop_front());
      if (v && !(byp && g)) q.push_back(e);
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    i_valid = 1'b0; i_flush = 1'b0; i_cdb_gnt = 1'b0;
    i_data = '0; i_addr = '0; i_tag = '0; i_redirect = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step(1'b0, mk(0, 0), 1'b1, 1'b0);
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  typedef struct {
    bit v; int tag; bit g;
    bit exp_req; int exp_tag; bit exp_full;
  } vec_t;

  vec_t       tbl[9];
  logic [TW-1:0] got[$];
  ent_t       z;

  initial begin
    z = mk(0, 0);
    do_reset();
    #1;
    chk("reset_req", 64'(o_cdb_req), 64'(0));
    chk("reset_full", 64'(o_full), 64'(0));

    // Single result with grant held.
    step(1'b1, mk(3, 32'h10), 1'b1, 1'b0);
    chk("single_first_req", 64'(s_req), 64'(BYP));
    step(1'b0, z, 1'b1, 1'b0);
    chk("single_second_req", 64'(s_req), 64'(!BYP));
    if (!BYP) chk("single_tag", 64'(s_tag), 64'(3));
    step(1'b0, z, 1'b1, 1'b0);
    chk("single_done", 64'(s_req), 64'(0));

    // Back-pressure: tags 1..4 with grant low (4th is the skid), then drain.
    tbl[0] = '{1'b1, 1, 1'b0, BYP,  1, 1'b0};
    tbl[1] = '{1'b1, 2, 1'b0, 1'b1, 1, 1'b0};
    tbl[2] = '{1'b1, 3, 1'b0, 1'b1, 1, 1'b0};
    tbl[3] = '{1'b1, 4, 1'b0, 1'b1, 1, 1'b1};
    tbl[4] = '{1'b0, 0, 1'b1, 1'b1, 1, 1'b1};
    tbl[5] = '{1'b0, 0, 1'b1, 1'b1, 2, 1'b1};
    tbl[6] = '{1'b0, 0, 1'b1, 1'b1, 3, 1'b0};
    tbl[7] = '{1'b0, 0, 1'b1, 1'b1, 4, 1'b0};
    tbl[8] = '{1'b0, 0, 1'b0, 1'b0, 0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, mk(tbl[i].tag, tbl[i].tag * 16), tbl[i].g, 1'b0);
      chk($sformatf("bp%0d_req", i), 64'(s_req), 64'(tbl[i].exp_req));
      chk($sformatf("bp%0d_full", i), 64'(s_full), 64'(tbl[i].exp_full));
      if (tbl[i].exp_req) chk($sformatf("bp%0d_tag", i), 64'(s_tag), 64'(tbl[i].exp_tag));
    end

    // Wrap-around: 10 results, grant toggling, issue honours the stall.
    begin
      int sent = 0;
      int cyc  = 0;
      bit g, v;
      got.delete();
      while ((sent < 10 || q.size() != 0) && cyc < 200) begin
        g = cyc[0];
        v = (sent < 10) && (q.size() < DEPTH - 1);
        step(v, mk(sent, 32'hA000 + sent), g, 1'b0);
        if (s_req && g) got.push_back(s_tag);
        if (v) sent++;
        cyc++;
      end
      chk("wrap_count", 64'(got.size()), 64'(10));
      for (int k = 0; k < got.size() && k < 10; k++)
        chk($sformatf("wrap_order%0d", k), 64'(got[k]), 64'(k));
    end

    // Simultaneous push and pop while holding DEPTH entries.
    for (int t = 1; t <= 4; t++) step(1'b1, mk(t, t), 1'b0, 1'b0);
    step(1'b1, mk(5, 5), 1'b1, 1'b0);
    chk("pp_head_before", 64'(s_tag), 64'(1));
    step(1'b0, z, 1'b0, 1'b0);
    chk("pp_head_after", 64'(s_tag), 64'(2));
    chk("pp_full", 64'(s_full), 64'(1));
    drain(8);

    // Flush with three held and a valid result in the flush cycle.
    for (int t = 1; t <= 3; t++) step(1'b1, mk(t, t), 1'b0, 1'b0);
    step(1'b1, mk(9, 9), 1'b1, 1'b1);
    step(1'b0, z, 1'b0, 1'b0);
    chk("flush_req", 64'(s_req), 64'(0));
    chk("flush_full", 64'(s_full), 64'(0));
    step(1'b1, mk(7, 32'h77), 1'b0, 1'b0);
    step(1'b0, z, 1'b1, 1'b0);
    chk("flush_next_tag", 64'(s_tag), 64'(7));
    chk("flush_next_req", 64'(s_req), 64'(1));
    drain(4);

    // Asynchronous reset in the middle of a cycle with two held.
    step(1'b1, mk(11, 1), 1'b0, 1'b0);
    step(1'b1, mk(12, 2), 1'b0, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_req", 64'(o_cdb_req), 64'(0));
    chk("async_rst_full", 64'(o_full), 64'(0));
    q.delete();
    i_valid = 1'b0; i_cdb_gnt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    step(1'b0, z, 1'b1, 1'b0);
    chk("post_rst_req", 64'(s_req), 64'(0));
    step(1'b0, z, 1'b0, 1'b0);

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      bit g, v, f;
      ent_t e;
      g = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 40) == 0);
      v = ($urandom_range(0, 1) == 1) && (q.size() < DEPTH || g);
      e.data = $urandom; e.addr = $urandom;
      e.tag = TW'($urandom); e.redirect = 1'($urandom);
      step(v, e, g, f);
    end
    drain(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
